// File: rtl/processing_unit_param.sv
// Parametrised RISC MCU datapath: register file, PC, IR, address register, two read buses,
// write-back bus, ALU and flags. Define PU_FLAGS_EXT_EN to add the C and N flags (Z-only otherwise).
module processing_unit_param #(
    parameter int DATA_W   = 8,
    parameter int WORD_W   = 10,
    parameter int ADDR_W   = 8,
    parameter int OP_W     = 4,
    parameter int NUM_REGS = 4,
    localparam int SEL1_W  = $clog2(NUM_REGS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WORD_W-1:0]          mem_word,
    input  logic [ADDR_W-1:0]          address_decoded,
    input  logic [DATA_W-1:0]          constant_decoded,
    input  logic [NUM_REGS-1:0]        load_reg,
    input  logic                       load_pc,
    input  logic                       inc_pc,
    input  logic                       load_ir,
    input  logic                       load_add_r,
    input  logic                       load_flags,
    input  logic [SEL1_W-1:0]          sel_bus_1a,
    input  logic [SEL1_W-1:0]          sel_bus_1b,
    input  logic [2:0]                 sel_bus_2,
    output logic [WORD_W-1:0]          instruction,
    output logic [ADDR_W-1:0]          address,
    output logic [ADDR_W-1:0]          pc_count,
    output logic [DATA_W-1:0]          bus_1a,
    output logic [DATA_W-1:0]          bus_1b,
    output logic [NUM_REGS*DATA_W-1:0] reg_file_out,
    output logic                       zflag,
    output logic                       cflag,
    output logic                       nflag
);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_NOT = OP_W'(4);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SHL = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SHR = OP_W'(8);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] ir;
    logic [ADDR_W-1:0] addr_r;
    logic [WORD_W-1:0] bus_2;
    logic [OP_W-1:0]   opcode;
    logic [DATA_W:0]   alu_wide;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    assign opcode      = ir[WORD_W-1 -: OP_W];
    assign instruction = ir;
    assign address     = addr_r;
    assign pc_count    = pc;

    // Select codes past the register count read the PC, then zero.
    always_comb begin
        bus_1a = '0;
        if (sel_bus_1a == SEL1_W'(NUM_REGS))
            bus_1a = DATA_W'(pc);
        for (int i = 0; i < NUM_REGS; i++)
            if (sel_bus_1a == SEL1_W'(i))
                bus_1a = regs[i];
    end

    always_comb begin
        bus_1b = '0;
        if (sel_bus_1b == SEL1_W'(NUM_REGS))
            bus_1b = DATA_W'(pc);
        for (int i = 0; i < NUM_REGS; i++)
            if (sel_bus_1b == SEL1_W'(i))
                bus_1b = regs[i];
    end

    // Bit DATA_W of alu_wide carries the carry/borrow/shifted-out bit.
    always_comb begin
        alu_wide = '0;
        case (opcode)
            OP_ADD:  alu_wide = {1'b0, bus_1b} + {1'b0, bus_1a};
            OP_SUB:  alu_wide = {1'b0, bus_1b} - {1'b0, bus_1a};
            OP_AND:  alu_wide = {1'b0, bus_1b & bus_1a};
            OP_NOT:  alu_wide = {1'b0, ~bus_1a};
            OP_OR:   alu_wide = {1'b0, bus_1b | bus_1a};
            OP_XOR:  alu_wide = {1'b0, bus_1b ^ bus_1a};
            OP_SHL:  alu_wide = {bus_1b, 1'b0};
            OP_SHR:  alu_wide = {bus_1b[0], 1'b0, bus_1b[DATA_W-1:1]};
            default: alu_wide = '0;
        endcase
    end

    assign alu_result = alu_wide[DATA_W-1:0];
    assign alu_carry  = alu_wide[DATA_W];

    always_comb begin
        bus_2 = '0;
        case (sel_bus_2)
            3'd0:    bus_2 = WORD_W'(alu_result);
            3'd1:    bus_2 = WORD_W'(bus_1a);
            3'd2:    bus_2 = mem_word;
            3'd3:    bus_2 = WORD_W'(address_decoded);
            3'd4:    bus_2 = WORD_W'(constant_decoded);
            3'd5:    bus_2 = WORD_W'(bus_1b);
            default: bus_2 = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (load_reg[i])
                    regs[i] <= bus_2[DATA_W-1:0];
        end
    end

    always_comb begin
        reg_file_out = '0;
        for (int i = 0; i < NUM_REGS; i++)
            reg_file_out[i*DATA_W +: DATA_W] = regs[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            ir     <= '0;
            addr_r <= '0;
        end else begin
            if (load_pc)
                pc <= bus_2[ADDR_W-1:0];
            else if (inc_pc)
                pc <= pc + ADDR_W'(1);
            if (load_ir)
                ir <= bus_2;
            if (load_add_r)
                addr_r <= bus_2[ADDR_W-1:0];
        end
    end

`ifdef PU_FLAGS_EXT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zflag <= 1'b0;
            cflag <= 1'b0;
            nflag <= 1'b0;
        end else if (load_flags) begin
            zflag <= (alu_result == '0);
            cflag <= alu_carry;
            nflag <= alu_result[DATA_W-1];
        end
    end
`else
    logic carry_unused;
    assign carry_unused = alu_carry;
    assign cflag        = 1'b0;
    assign nflag        = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            zflag <= 1'b0;
        else if (load_flags)
            zflag <= (alu_result == '0);
    end
`endif

endmodule

// File: tb/tb_processing_unit_param.sv
// Self-checking bench for processing_unit_param: table-driven ALU/flag vectors, hand sequences
// for reset/PC/IR corner cases, and random control traffic against a behavioural model.
module tb_processing_unit_param;

    localparam int DATA_W   = 8;
    localparam int WORD_W   = 10;
    localparam int ADDR_W   = 8;
    localparam int OP_W     = 4;
    localparam int NUM_REGS = 4;
    localparam int SEL1_W   = $clog2(NUM_REGS + 1);
    localparam int DM       = 1 << DATA_W;
    localparam int AM       = 1 << ADDR_W;
    localparam int WM       = 1 << WORD_W;
    localparam int OP_SHIFT = WORD_W - OP_W;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [WORD_W-1:0]          mem_word;
    logic [ADDR_W-1:0]          address_decoded;
    logic [DATA_W-1:0]          constant_decoded;
    logic [NUM_REGS-1:0]        load_reg;
    logic                       load_pc, inc_pc, load_ir, load_add_r, load_flags;
    logic [SEL1_W-1:0]          sel_bus_1a, sel_bus_1b;
    logic [2:0]                 sel_bus_2;
    logic [WORD_W-1:0]          instruction;
    logic [ADDR_W-1:0]          address;
    logic [ADDR_W-1:0]          pc_count;
    logic [DATA_W-1:0]          bus_1a, bus_1b;
    logic [NUM_REGS*DATA_W-1:0] reg_file_out;
    logic                       zflag, cflag, nflag;

    processing_unit_param #(
        .DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .NUM_REGS(NUM_REGS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem_word(mem_word), .address_decoded(address_decoded),
        .constant_decoded(constant_decoded), .load_reg(load_reg), .load_pc(load_pc),
        .inc_pc(inc_pc), .load_ir(load_ir), .load_add_r(load_add_r), .load_flags(load_flags),
        .sel_bus_1a(sel_bus_1a), .sel_bus_1b(sel_bus_1b), .sel_bus_2(sel_bus_2),
        .instruction(instruction), .address(address), .pc_count(pc_count),
        .bus_1a(bus_1a), .bus_1b(bus_1b), .reg_file_out(reg_file_out),
        .zflag(zflag), .cflag(cflag), .nflag(nflag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WORD_W-1:0]   mem;
        logic [ADDR_W-1:0]   adec;
        logic [DATA_W-1:0]   cdec;
        logic [NUM_REGS-1:0] ld_reg;
        logic                ld_pc;
        logic                inc;
        logic                ld_ir;
        logic                ld_addr;
        logic                ld_flags;
        logic [SEL1_W-1:0]   s1a;
        logic [SEL1_W-1:0]   s1b;
        logic [2:0]          s2;
    } ctrl_t;

    typedef struct {
        int op;
        int a;
        int b;
        int res;
        bit z;
        bit c;
        bit n;
    } alu_vec_t;

    int vectorCount = 0;
    int missCount   = 0;

    int m_regs [NUM_REGS];
    int m_pc, m_ir, m_addr;
    bit m_z, m_c, m_n;

    function automatic ctrl_t idleCtrl();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

    task automatic applyStimulus(input ctrl_t c);
        mem_word         = c.mem;
        address_decoded  = c.adec;
        constant_decoded = c.cdec;
        load_reg         = c.ld_reg;
        load_pc          = c.ld_pc;
        inc_pc           = c.inc;
        load_ir          = c.ld_ir;
        load_add_r       = c.ld_addr;
        load_flags       = c.ld_flags;
        sel_bus_1a       = c.s1a;
        sel_bus_1b       = c.s1b;
        sel_bus_2        = c.s2;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_REGS; i++)
            m_regs[i] = 0;
        m_pc = 0; m_ir = 0; m_addr = 0;
        m_z = 0; m_c = 0; m_n = 0;
    endtask

    function automatic int readBus(input int sel);
        if (sel < NUM_REGS)
            return m_regs[sel];
        if (sel == NUM_REGS)
            return m_pc % DM;
        return 0;
    endfunction

    task automatic aluModel(input int op, input int a, input int b, output int res, output bit carry);
        int full;
        carry = 0;
        case (op)
            1:       begin full = b + a; res = full % DM; carry = (full >= DM); end
            2:       begin res = (b - a + DM) % DM; carry = (b < a); end
            3:       res = b & a;
            4:       res = (DM - 1) - a;
            5:       res = b | a;
            6:       res = b ^ a;
            7:       begin full = b * 2; res = full % DM; carry = (full >= DM); end
            8:       begin res = b / 2; carry = (b % 2) == 1; end
            default: res = 0;
        endcase
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelEdge();
        int a, b, res, bus2;
        bit carry;
        if (!rst_n) begin
            modelReset();
            return;
        end
        a = readBus(int'(sel_bus_1a));
        b = readBus(int'(sel_bus_1b));
        aluModel(m_ir / (1 << OP_SHIFT), a, b, res, carry);
        case (int'(sel_bus_2))
            0:       bus2 = res;
            1:       bus2 = a;
            2:       bus2 = int'(mem_word);
            3:       bus2 = int'(address_decoded);
            4:       bus2 = int'(constant_decoded);
            5:       bus2 = b;
            default: bus2 = 0;
        endcase
        for (int i = 0; i < NUM_REGS; i++)
            if (load_reg[i])
                m_regs[i] = bus2 % DM;
        if (load_pc)
            m_pc = bus2 % AM;
        else if (inc_pc)
            m_pc = (m_pc + 1) % AM;
        if (load_ir)
            m_ir = bus2 % WM;
        if (load_add_r)
            m_addr = bus2 % AM;
        if (load_flags) begin
            m_z = (res == 0);
`ifdef PU_FLAGS_EXT_EN
            m_c = carry;
            m_n = (res >= DM / 2);
`endif
        end
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_pc"}, int'(pc_count), m_pc);
        checkOutput({tag, "_ir"}, int'(instruction), m_ir);
        checkOutput({tag, "_addr"}, int'(address), m_addr);
        for (int i = 0; i < NUM_REGS; i++)
            checkOutput($sformatf("%s_r%0d", tag, i), int'(reg_file_out[i*DATA_W +: DATA_W]), m_regs[i]);
        checkOutput({tag, "_bus1a"}, int'(bus_1a), readBus(int'(sel_bus_1a)));
        checkOutput({tag, "_bus1b"}, int'(bus_1b), readBus(int'(sel_bus_1b)));
        checkOutput({tag, "_z"}, int'(zflag), int'(m_z));
        checkOutput({tag, "_c"}, int'(cflag), int'(m_c));
        checkOutput({tag, "_n"}, int'(nflag), int'(m_n));
    endtask

    task automatic loadConst(input int idx, input int val);
        ctrl_t c;
        c = idleCtrl();
        c.cdec = DATA_W'(val);
        c.s2 = 3'd4;
        c.ld_reg = NUM_REGS'(1 << idx);
        applyStimulus(c);
        tick();
    endtask

    task automatic loadIr(input int word);
        ctrl_t c;
        c = idleCtrl();
        c.mem = WORD_W'(word);
        c.s2 = 3'd2;
        c.ld_ir = 1'b1;
        applyStimulus(c);
        tick();
    endtask

    // R0 -> bus_1a, R1 -> bus_1b, ALU result written into R3 with optional flag load.
    task automatic aluToR3(input bit with_flags);
        ctrl_t c;
        c = idleCtrl();
        c.s1a = SEL1_W'(0);
        c.s1b = SEL1_W'(1);
        c.s2 = 3'd0;
        c.ld_reg = NUM_REGS'(4'b1000);
        c.ld_flags = with_flags;
        applyStimulus(c);
        tick();
    endtask

    alu_vec_t alu_tab [12];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ctrl_t c;
        bit exp_c, exp_n;

        alu_tab[0]  = '{1, 'hF0, 'h20, 'h10, 0, 1, 0};
        alu_tab[1]  = '{2, 'h33, 'h33, 'h00, 1, 0, 0};
        alu_tab[2]  = '{2, 'h05, 'h03, 'hFE, 0, 1, 1};
        alu_tab[3]  = '{3, 'hF0, 'h3C, 'h30, 0, 0, 0};
        alu_tab[4]  = '{4, 'h0F, 'h00, 'hF0, 0, 0, 1};
        alu_tab[5]  = '{5, 'h00, 'h00, 'h00, 1, 0, 0};
        alu_tab[6]  = '{6, 'hAA, 'h55, 'hFF, 0, 0, 1};
        alu_tab[7]  = '{7, 'h00, 'h81, 'h02, 0, 1, 0};
        alu_tab[8]  = '{8, 'h00, 'h81, 'h40, 0, 1, 0};
        alu_tab[9]  = '{0, 'h12, 'h34, 'h00, 1, 0, 0};
        alu_tab[10] = '{14, 'hFF, 'hFF, 'h00, 1, 0, 0};
        alu_tab[11] = '{1, 'h7F, 'h01, 'h80, 0, 0, 1};

        rst_n = 1'b0;
        applyStimulus(idleCtrl());
        modelReset();
        #12;
        checkAll("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            loadConst(0, alu_tab[i].a);
            loadConst(1, alu_tab[i].b);
            loadIr(alu_tab[i].op << OP_SHIFT);
            aluToR3(1'b1);
`ifdef PU_FLAGS_EXT_EN
            exp_c = alu_tab[i].c;
            exp_n = alu_tab[i].n;
`else
            exp_c = 1'b0;
            exp_n = 1'b0;
`endif
            checkOutput($sformatf("alu%0d_res", i), int'(reg_file_out[3*DATA_W +: DATA_W]), alu_tab[i].res);
            checkOutput($sformatf("alu%0d_z", i), int'(zflag), int'(alu_tab[i].z));
            checkOutput($sformatf("alu%0d_c", i), int'(cflag), int'(exp_c));
            checkOutput($sformatf("alu%0d_n", i), int'(nflag), int'(exp_n));
        end

        // Flags hold when load_flags is low even though the ALU result changes.
        loadConst(0, 'h33);
        loadConst(1, 'h33);
        loadIr(2 << OP_SHIFT);
        aluToR3(1'b1);
        checkOutput("sub_zero_z", int'(zflag), 1);
        loadConst(0, 'h01);
        aluToR3(1'b0);
        checkOutput("hold_r3", int'(reg_file_out[3*DATA_W +: DATA_W]), 'h32);
        checkOutput("hold_z", int'(zflag), 1);
        checkOutput("hold_c", int'(cflag), 0);

        // PC wrap, load-over-increment priority, PC on the read bus.
        c = idleCtrl();
        c.adec = ADDR_W'('hFF);
        c.s2 = 3'd3;
        c.ld_pc = 1'b1;
        applyStimulus(c);
        tick();
        checkOutput("pc_ff", int'(pc_count), 'hFF);
        c = idleCtrl();
        c.inc = 1'b1;
        applyStimulus(c);
        tick();
        checkOutput("pc_wrap", int'(pc_count), 'h00);
        c = idleCtrl();
        c.adec = ADDR_W'('h40);
        c.s2 = 3'd3;
        c.ld_pc = 1'b1;
        c.inc = 1'b1;
        applyStimulus(c);
        tick();
        checkOutput("pc_load_prio", int'(pc_count), 'h40);
        c = idleCtrl();
        c.s1a = SEL1_W'(NUM_REGS);
        applyStimulus(c);
        #1;
        checkOutput("bus1a_pc", int'(bus_1a), 'h40);

        // Undefined opcode gives a zero result; out-of-range selects read zero.
        loadIr('h3A5);
        checkOutput("ir_3a5", int'(instruction), 'h3A5);
        for (int s = NUM_REGS + 1; s < (1 << SEL1_W); s++) begin
            c = idleCtrl();
            c.s1a = SEL1_W'(s);
            applyStimulus(c);
            #1;
            checkOutput($sformatf("bus1a_sel%0d", s), int'(bus_1a), 0);
        end
        loadConst(3, 'hAB);
        aluToR3(1'b1);
        checkOutput("opE_res", int'(reg_file_out[3*DATA_W +: DATA_W]), 0);
        checkOutput("opE_z", int'(zflag), 1);

        // Random control traffic against the model, with occasional async resets.
        for (int cyc = 0; cyc < 400; cyc++) begin
            c.mem      = WORD_W'($urandom_range(0, WM - 1));
            c.adec     = ADDR_W'($urandom_range(0, AM - 1));
            c.cdec     = DATA_W'($urandom_range(0, DM - 1));
            c.ld_reg   = NUM_REGS'($urandom_range(0, (1 << NUM_REGS) - 1));
            c.ld_pc    = ($urandom_range(0, 7) == 0);
            c.inc      = ($urandom_range(0, 2) == 0);
            c.ld_ir    = ($urandom_range(0, 3) == 0);
            c.ld_addr  = ($urandom_range(0, 3) == 0);
            c.ld_flags = ($urandom_range(0, 1) == 0);
            c.s1a      = SEL1_W'($urandom_range(0, (1 << SEL1_W) - 1));
            c.s1b      = SEL1_W'($urandom_range(0, (1 << SEL1_W) - 1));
            c.s2       = 3'($urandom_range(0, 7));
            applyStimulus(c);
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                #1;
                modelReset();
                checkAll("rnd_rst");
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
                checkAll("rnd");
            end
        end

        // Reset mid-run with all register loads requested, then a first post-reset load.
        loadConst(2, 'hC3);
        c = idleCtrl();
        c.cdec = DATA_W'('h77);
        c.s2 = 3'd4;
        c.ld_reg = NUM_REGS'(4'hF);
        applyStimulus(c);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_regs", int'(reg_file_out), 0);
        checkAll("rst_mid");
        tick();
        checkOutput("rst_hold_regs", int'(reg_file_out), 0);
        rst_n = 1'b1;
        c = idleCtrl();
        c.cdec = DATA_W'('h5A);
        c.s2 = 3'd4;
        c.ld_reg = NUM_REGS'(4'b0100);
        applyStimulus(c);
        tick();
        checkOutput("post_rst_r2", int'(reg_file_out[23:16]), 'h5A);
        checkAll("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
